_mux_arb: RTL and testbench
===========================

// Module: _mux_arb
// PURPOSE
//  Parametrised N-channel registered multiplexer with valid/ready handshake on every input and the output.
//  Selects a channel by fixed select or by round-robin arbitration.
//  Sits between multiple producers (e.g. register-file read ports, bus masters) and a single consumer.
//  Replaces fixed-width combinational mux trees where back-pressure is needed.
// PARAMETERS
//  n          constants::WORD_LENGTH   data width in bits
//  CHANNELS   8                        number of inputs, >=2, need not be a power of 2
//  SELW       $clog2(CHANNELS)         select/index width (derived, do not override)
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              reset, asynchronous, active-high
//  mode       in   1              mux_mode_t: MUX_FIXED=0, MUX_RR=1
//  sel        in   SELW           channel index, used in MUX_FIXED only
//  in_valid   in   CHANNELS       per-channel data valid
//  in_ready   out  CHANNELS       per-channel accept (one-hot or zero)
//  in         in   n x CHANNELS   unpacked array in[CHANNELS-1:0] of [n-1:0] data
//  out_valid  out  1              registered output valid
//  out_ready  in   1              consumer accept
//  out        out  n              registered output data
//  out_ch     out  SELW           channel index of the beat held in out
// BEHAVIOUR
//  - Reset (async, rst=1): out_valid=0, out=0, out_ch=0, rr_ptr=0; in_ready=0 while rst=1.
//  - load = !out_valid || out_ready. A transfer happens on channel g when load && grant[g]; then in_ready[g]=1.
//  - in_ready is combinational from load and grant. Its valid-to-ready path does not depend on in_ready.
//  - Latency: accepted beat appears on out/out_ch with out_valid=1 the next cycle.
//  - Throughput is 1 beat/cycle when out_ready is held at 1.
//  - If load && no grant, out_valid <= 0 next cycle.
//  - If out_valid && !out_ready, out, out_ch and out_valid hold.
//  - MUX_FIXED: grant=onehot(sel) iff sel<CHANNELS && in_valid[sel].
//    - sel>=CHANNELS gives no grant and is never an X source.
//    - rr_ptr is unchanged in this mode.
//  - MUX_RR: grant = first valid channel scanning rr_ptr, rr_ptr+1, ... CHANNELS-1, 0, ... (wrap-around).
//    - On transfer, rr_ptr <= (g==CHANNELS-1) ? 0 : g+1.
//    - No transfer: rr_ptr holds.
//  - mode/sel changes take effect at the next arbitration; a beat already in out is never dropped or altered.
//  - Reset asserted mid-transfer discards the held beat; no in_ready is issued until rst deasserts.
//  - Producers must hold in/in_valid until in_ready. The block does not check this.
// CONFIGURATION
//  ARB_MUX_LOCK_EN defined:
//    - Adds ports in_last (in, CHANNELS) and out_last (out, 1, reset 0), registered alongside out.
//    - Once channel g transfers a beat with in_last[g]=0, grant locks to g (mode/sel ignored) until a beat with in_last[g]=1 transfers.
//    - rr_ptr advances only on that last beat.
//    - While locked, other channels get in_ready=0 even if g is idle.
//  ARB_MUX_LOCK_EN undefined:
//    - No last ports; every beat re-arbitrates as above.
// STRUCTURE
//  - constants package:
//    - typedef enum logic {MUX_FIXED, MUX_RR} mux_mode_t.
//    - Default CHANNELS constant MUX_ARB_CHANNELS=8.
//  - Sub-module _rr_arbiter #(CHANNELS):
//    - Purely combinational.
//    - Inputs: req, ptr. Outputs: one-hot gnt, index gnt_idx, any.
//    - Implemented as a double-width masked priority scan.
//  - Top holds the output register, rr_ptr, lock state, fixed/RR grant select and data mux.
// TESTING
//  T1 reset:
//    - rst pulsed mid-cycle with out_valid=1 -> out_valid, out, out_ch drop to 0 asynchronously; in_ready=0.
//  T2 fixed select:
//    - mode=0, sel=5, all valid, in[i]=8'hA0+i, out_ready=1 -> in_ready=8'h20; next cycle out=8'hA5, out_ch=5.
//    - sel=9 with CHANNELS=10 selects in[9].
//    - sel=7 with CHANNELS=6 -> in_ready=0, out_valid=0.
//  T3 round-robin fairness/wrap (CHANNELS=6):
//    - All valid, out_ready=1 -> out_ch 0,1,2,3,4,5,0,...
//    - Only ch4 & ch1 valid with rr_ptr=5 -> ch1 then ch4.
//  T4 back-pressure:
//    - out_ready=0 for 3 cycles with beat held -> out stable, in_ready=0.
//    - out_ready=1 -> next beat accepted the same cycle, out updates the following cycle, no bubble.
//  T5 mode switch:
//    - Change RR->FIXED while out_valid && !out_ready -> held beat emitted unchanged; the next beat follows sel.
//  T6 (ARB_MUX_LOCK_EN) lock:
//    - ch2 sends 3 beats, last on the 3rd, while ch0/ch1 valid in RR -> out_ch=2,2,2; then ch0 follows (rr_ptr=3 wraps to 0); out_last=1 only on the 3rd beat.

Source files
------------

// File: rtl/_mux_arb_pkg.sv
// rtl/_mux_arb_pkg.sv - shared constants and mode type for the registered channel mux
package constants;

  localparam int WORD_LENGTH      = 8;
  localparam int MUX_ARB_CHANNELS = 8;

  typedef enum logic {
    MUX_FIXED = 1'b0,
    MUX_RR    = 1'b1
  } mux_mode_t;

endpackage

// File: rtl/_mux_arb_rr_arbiter.sv
// rtl/_mux_arb_rr_arbiter.sv - combinational round-robin arbiter, double-width masked priority scan
module _rr_arbiter #(
  parameter int CHANNELS = 8,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SELW-1:0]     ptr,
  output logic [CHANNELS-1:0] gnt,
  output logic [SELW-1:0]     gnt_idx,
  output logic                any
);

  logic [CHANNELS-1:0]   mask;
  logic [2*CHANNELS-1:0] dbl;

  // Lower half keeps only requests at or above ptr, upper half holds all of them,
  // so the lowest set bit is the first requester scanning from ptr with wrap-around.
  always_comb begin
    mask    = '0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      mask[i] = (SELW'(i) >= ptr);
    end
    dbl = {req, req & mask};
    for (int i = 0; i < 2 * CHANNELS; i++) begin
      if (dbl[i] && !any) begin
        any     = 1'b1;
        gnt_idx = (i >= CHANNELS) ? SELW'(i - CHANNELS) : SELW'(i);
      end
    end
    for (int j = 0; j < CHANNELS; j++) begin
      gnt[j] = any && (gnt_idx == SELW'(j));
    end
  end

endmodule

// File: rtl/_mux_arb.sv
// rtl/_mux_arb.sv - N-channel registered mux with fixed/round-robin select; ARB_MUX_LOCK_EN adds burst lock
module _mux_arb
  import constants::*;
#(
  parameter int n        = WORD_LENGTH,
  parameter int CHANNELS = MUX_ARB_CHANNELS,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  mux_mode_t           mode,
  input  logic [SELW-1:0]     sel,
  input  logic [CHANNELS-1:0] in_valid,
  output logic [CHANNELS-1:0] in_ready,
  input  logic [n-1:0]        in [CHANNELS-1:0],
  output logic                out_valid,
  input  logic                out_ready,
  output logic [n-1:0]        out,
  output logic [SELW-1:0]     out_ch
`ifdef ARB_MUX_LOCK_EN
  ,
  input  logic [CHANNELS-1:0] in_last,
  output logic                out_last
`endif
);

  logic                out_valid_q, out_valid_d;
  logic [n-1:0]        out_q, out_d;
  logic [SELW-1:0]     out_ch_q, out_ch_d;
  logic [SELW-1:0]     rr_ptr_q, rr_ptr_d;

  logic [CHANNELS-1:0] rr_gnt, fixed_gnt, grant;
  logic [SELW-1:0]     rr_idx, gnt_idx;
  logic                rr_any, fixed_any, gnt_any;
  logic                load, xfer, gnt_last;
  logic [n-1:0]        gnt_data;

`ifdef ARB_MUX_LOCK_EN
  logic                out_last_q, out_last_d;
  logic                lock_q, lock_d;
  logic [SELW-1:0]     lock_ch_q, lock_ch_d;
`endif

  _rr_arbiter #(.CHANNELS(CHANNELS), .SELW(SELW)) u_rr (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .any     (rr_any)
  );

  // Fixed select compares against every index so an out-of-range sel yields no grant and no X.
  always_comb begin
    fixed_gnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      fixed_gnt[i] = (sel == SELW'(i)) && in_valid[i];
    end
    fixed_any = |fixed_gnt;
  end

  // Pick the active grant source; an open burst overrides mode and sel.
  always_comb begin
    grant   = (mode == MUX_RR) ? rr_gnt : fixed_gnt;
    gnt_idx = (mode == MUX_RR) ? rr_idx : sel;
    gnt_any = (mode == MUX_RR) ? rr_any : fixed_any;
`ifdef ARB_MUX_LOCK_EN
    if (lock_q) begin
      for (int i = 0; i < CHANNELS; i++) begin
        grant[i] = (lock_ch_q == SELW'(i)) && in_valid[i];
      end
      gnt_idx = lock_ch_q;
      gnt_any = |grant;
    end
`endif
  end

  // One-hot data and last-flag select driven by the grant vector.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) gnt_data = gnt_data | in[i];
    end
`ifdef ARB_MUX_LOCK_EN
    gnt_last = |(grant & in_last);
`else
    gnt_last = 1'b1;
`endif
  end

  assign load     = !out_valid_q || out_ready;
  assign xfer     = load && gnt_any;
  assign in_ready = (load && !rst) ? grant : '0;

  // Next-state for output register, round-robin pointer and burst lock.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef ARB_MUX_LOCK_EN
    out_last_d  = out_last_q;
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
`endif
    if (load) begin
      out_valid_d = gnt_any;
      if (gnt_any) begin
        out_d    = gnt_data;
        out_ch_d = gnt_idx;
`ifdef ARB_MUX_LOCK_EN
        out_last_d = gnt_last;
`endif
      end
    end
    if (xfer) begin
`ifdef ARB_MUX_LOCK_EN
      lock_d    = !gnt_last;
      lock_ch_d = gnt_idx;
`endif
      if (mode == MUX_RR && gnt_last) begin
        rr_ptr_d = (gnt_idx == SELW'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // State registers; reset clears the held beat immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
`ifdef ARB_MUX_LOCK_EN
      out_last_q  <= 1'b0;
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef ARB_MUX_LOCK_EN
      out_last_q  <= out_last_d;
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_ch    = out_ch_q;
`ifdef ARB_MUX_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb__mux_arb.sv
// tb/tb__mux_arb.sv - directed plus randomized bench for _mux_arb against a behavioural model
module tb__mux_arb;
  import constants::*;

  localparam int CH = 6;
  localparam int W  = 8;
  localparam int SW = $clog2(CH);

  logic          clk = 1'b0;
  logic          rst;
  mux_mode_t     mode;
  logic [SW-1:0] sel;
  logic [CH-1:0] in_valid;
  logic [CH-1:0] in_ready;
  logic [W-1:0]  din [CH-1:0];
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  dout;
  logic [SW-1:0] out_ch;
`ifdef ARB_MUX_LOCK_EN
  logic [CH-1:0] in_last;
  logic          out_last;
`endif

  int errors = 0;
  int checks = 0;

  // behavioural model state
  bit       m_ov;
  int       m_out;
  int       m_ch;
  int       m_ptr;
  bit       m_lock;
  int       m_lock_ch;
  bit       m_last;

  _mux_arb #(.n(W), .CHANNELS(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .out_ch    (out_ch)
`ifdef ARB_MUX_LOCK_EN
    ,
    .in_last   (in_last),
    .out_last  (out_last)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ov = 0; m_out = 0; m_ch = 0; m_ptr = 0; m_lock = 0; m_lock_ch = 0; m_last = 0;
  endtask

  // Which channel would win right now, from the arbitration rules.
  task automatic pick(output int g, output bit any);
    g = 0;
    any = 0;
    if (m_lock) begin
      g = m_lock_ch;
      any = in_valid[g];
    end else if (mode == MUX_FIXED) begin
      if (int'(sel) < CH && in_valid[sel]) begin
        g = int'(sel);
        any = 1;
      end
    end else begin
      for (int k = 0; k < CH; k++) begin
        int c;
        c = (m_ptr + k) % CH;
        if (!any && in_valid[c]) begin
          g = c;
          any = 1;
        end
      end
    end
  endtask

  // Called at a falling edge with inputs already applied: check, then advance one clock.
  task automatic tick();
    int g;
    bit any, load, adv;
    logic [CH-1:0] er;
    #1;
    pick(g, any);
    load = !m_ov || out_ready;
    er = '0;
    if (!rst && load && any) er[g] = 1'b1;
    chk("in_ready", in_ready, er);
    chk("out_valid", out_valid, m_ov);
    chk("out", dout, m_out);
    chk("out_ch", out_ch, m_ch);
`ifdef ARB_MUX_LOCK_EN
    chk("out_last", out_last, m_last);
`endif
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else if (load) begin
      if (any) begin
        m_ov = 1;
        m_out = din[g];
        m_ch = g;
        adv = 1;
`ifdef ARB_MUX_LOCK_EN
        m_last = in_last[g];
        m_lock = !in_last[g];
        m_lock_ch = g;
        adv = in_last[g];
`endif
        if (adv && mode == MUX_RR) m_ptr = (g + 1) % CH;
      end else begin
        m_ov = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] held;
    rst = 1; mode = MUX_FIXED; sel = '0; in_valid = '0; out_ready = 0;
    for (int i = 0; i < CH; i++) din[i] = '0;
`ifdef ARB_MUX_LOCK_EN
    in_last = '1;
`endif
    m_reset();
    @(negedge clk);
    in_valid = '1;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);

    // fixed select
    rst = 0; mode = MUX_FIXED; sel = 5; out_ready = 1;
    for (int i = 0; i < CH; i++) din[i] = W'(8'hA0 + i);
    #1 chk("fix_in_ready", in_ready, 6'h20);
    tick();
    chk("fix_out", dout, 8'hA5);
    chk("fix_out_ch", out_ch, 5);
    sel = 7;
    tick();
    chk("oob_out_valid", out_valid, 0);
    chk("oob_in_ready", in_ready, 0);

    // round-robin wrap
    mode = MUX_RR;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("rr_seq", out_ch, c % CH);
    end
    for (int c = 0; c < 12 && m_ptr != 5; c++) tick();
    in_valid = 6'b010010;
    tick();
    chk("rr_sparse1", out_ch, 1);
    tick();
    chk("rr_sparse2", out_ch, 4);

    // back-pressure
    in_valid = '1; out_ready = 0;
    held = dout;
    for (int c = 0; c < 3; c++) tick();
    chk("bp_hold", dout, held);
    chk("bp_ready0", in_ready, 0);
    out_ready = 1;
    #1 chk("bp_accept", (in_ready != 0), 1);
    tick();
    chk("bp_valid", out_valid, 1);

    // mode switch while a beat is held
    out_ready = 0;
    tick();
    held = dout;
    mode = MUX_FIXED; sel = 2;
    tick();
    chk("ms_hold", dout, held);
    out_ready = 1;
    tick();
    chk("ms_follow", out_ch, 2);

    // asynchronous reset mid-cycle with a held beat
    #2 rst = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_out", dout, 0);
    chk("arst_ch", out_ch, 0);
    chk("arst_ready", in_ready, 0);
    m_reset();
    @(negedge clk);
    rst = 0;

`ifdef ARB_MUX_LOCK_EN
    // burst lock: move pointer to 2, then ch2 sends a 3-beat burst
    mode = MUX_RR; in_valid = 6'b000010; in_last = '1;
    tick();
    in_valid = 6'b000111;
    for (int b = 0; b < 3; b++) begin
      in_last[2] = (b == 2);
      tick();
      chk("lock_ch", out_ch, 2);
      chk("lock_last", out_last, (b == 2));
    end
    tick();
    chk("lock_after", out_ch, 0);
`endif

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      mode = mux_mode_t'($urandom_range(0, 1));
      sel = SW'($urandom_range(0, 7));
      in_valid = CH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < CH; i++) din[i] = W'($urandom);
`ifdef ARB_MUX_LOCK_EN
      in_last = CH'($urandom);
`endif
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
